// File: rtl/cell_pos_reader_pkg.sv
// -----------------------------------------------------------------------------
// cell_pos_reader_pkg
// Shared constants and types for the cell position reader:
//   - default geometry of the cell memory and of the output buffer
//   - FSM state encoding used by cell_pos_reader
// No ports (package).
// -----------------------------------------------------------------------------
package cell_pos_reader_pkg;

  localparam int CPR_DATA_WIDTH   = 96;   // {posz, posy, posx}
  localparam int CPR_PARTICLE_NUM = 220;  // words in the cell memory
  localparam int CPR_ADDR_WIDTH   = 8;    // cell-memory address width
  localparam int CPR_FIFO_DEPTH   = 4;    // output buffer depth, power of 2, >= 4

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_CNT   = 3'd1,
    ST_WAIT_CNT = 3'd2,
    ST_STREAM   = 3'd3,
    ST_DONE     = 3'd4
  } cpr_state_e;

endpackage

// File: rtl/cell_pos_fifo.sv
// -----------------------------------------------------------------------------
// cell_pos_fifo
// First-word-fall-through buffer between the cell-memory read pipeline and
// the output stream. The head word is presented on rd_data whenever valid=1
// and is forced to zero while the buffer is empty.
// Ports:
//   clock, rst         sole clock, synchronous active-high reset
//   wr_en, wr_data     push one word (caller guarantees no overflow)
//   rd_en              pop the head word (ignored when empty)
//   rd_data, valid     head word and its presence flag
//   count              current occupancy
// -----------------------------------------------------------------------------
module cell_pos_fifo
  import cell_pos_reader_pkg::*;
#(
  parameter int WIDTH = CPR_DATA_WIDTH + CPR_ADDR_WIDTH,
  parameter int DEPTH = CPR_FIFO_DEPTH
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             not_empty_s;
  logic             pop_s;

  assign not_empty_s = (count_r != {CNT_W{1'b0}});
  assign pop_s       = rd_en & not_empty_s;
  assign valid       = not_empty_s;
  assign count       = count_r;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (wr_en) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      count_r <= count_r + CNT_W'(wr_en) - CNT_W'(pop_s);
    end
  end

  // Storage array; contents need no reset because the head is masked when empty.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Head word presented combinationally (fall-through), zero while empty.
  always_comb begin
    rd_data = {WIDTH{1'b0}};
    if (not_empty_s) begin
      rd_data = mem_r[rd_ptr_r];
    end else begin
      rd_data = {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/cell_pos_reader.sv
// -----------------------------------------------------------------------------
// cell_pos_reader
// On a start pulse, reads the particle count from cell-memory word 0 (clamped
// to PARTICLE_NUM-1), then reads words 1..count in order and streams them out
// with their address, throttled so that in-flight reads plus buffered words
// never exceed FIFO_DEPTH. The memory has a fixed 2-cycle read latency.
// Ports:
//   clock, rst                 sole clock, synchronous active-high reset
//   start                      one-cycle read-out request (ignored when not idle)
//   mem_address/mem_rden/mem_wren/mem_q   cell-memory read port
//   out_pos/out_id/out_valid/out_ready/out_last   position stream
//   busy, done                 read-out in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module cell_pos_reader
  import cell_pos_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = CPR_DATA_WIDTH,
  parameter int PARTICLE_NUM = CPR_PARTICLE_NUM,
  parameter int ADDR_WIDTH   = CPR_ADDR_WIDTH,
  parameter int FIFO_DEPTH   = CPR_FIFO_DEPTH
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] out_pos,
  output logic [ADDR_WIDTH-1:0] out_id,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int FW    = DATA_WIDTH + ADDR_WIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  cpr_state_e            state_r;
  logic                  wait_phase_r;
  logic [ADDR_WIDTH-1:0] count_r;
  logic [ADDR_WIDTH-1:0] next_addr_r;
  logic [ADDR_WIDTH-1:0] mem_address_r;
  logic                  mem_rden_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  fly1_r;
  logic                  fly2_r;
  logic [ADDR_WIDTH-1:0] fly1_addr_r;
  logic [ADDR_WIDTH-1:0] fly2_addr_r;

  logic [FW-1:0]         fifo_rd_data_s;
  logic                  fifo_valid_s;
  logic [CNT_W-1:0]      fifo_count_s;
  logic                  pop_s;
  logic [ADDR_WIDTH-1:0] clamp_count_s;
  logic [SUM_W-1:0]      backlog_s;
  logic                  can_issue_s;
  logic                  last_s;
  logic                  last_xfer_s;

  assign mem_address = mem_address_r;
  assign mem_rden    = mem_rden_r;
  assign mem_wren    = 1'b0;
  assign busy        = busy_r;
  assign done        = done_r;
  assign out_valid   = fifo_valid_s;
  assign out_pos     = fifo_rd_data_s[DATA_WIDTH-1:0];
  assign out_id      = fifo_rd_data_s[FW-1:DATA_WIDTH];
  assign out_last    = last_s;
  assign pop_s       = fifo_valid_s & out_ready;
  assign last_xfer_s = last_s & out_ready;

  // Occupancy expected next cycle before any new issue: the word landing now
  // (fly2) moves into the FIFO, so it stays counted either way.
  assign backlog_s = SUM_W'(fifo_count_s) + SUM_W'(mem_rden_r) + SUM_W'(fly1_r)
                   + SUM_W'(fly2_r) - SUM_W'(pop_s);

  // Count clamp and issue / last-beat decisions.
  always_comb begin
    clamp_count_s = mem_q[ADDR_WIDTH-1:0];
    can_issue_s   = 1'b0;
    last_s        = 1'b0;
    if (mem_q[ADDR_WIDTH-1:0] > MAX_COUNT) begin
      clamp_count_s = MAX_COUNT;
    end else begin
      clamp_count_s = mem_q[ADDR_WIDTH-1:0];
    end
    if ((next_addr_r <= count_r) && (backlog_s < SUM_W'(FIFO_DEPTH))) begin
      can_issue_s = 1'b1;
    end else begin
      can_issue_s = 1'b0;
    end
    if ((state_r == ST_STREAM) && fifo_valid_s && (out_id == count_r)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Read-latency tracker: tags each data read with its address for 2 cycles;
  // cleared on reset so returns from abandoned reads are dropped.
  always_ff @(posedge clock) begin
    if (rst) begin
      fly1_r      <= 1'b0;
      fly2_r      <= 1'b0;
      fly1_addr_r <= {ADDR_WIDTH{1'b0}};
      fly2_addr_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      fly1_r      <= mem_rden_r & (state_r == ST_STREAM);
      fly2_r      <= fly1_r;
      fly1_addr_r <= mem_address_r;
      fly2_addr_r <= fly1_addr_r;
    end
  end

  // Control FSM with registered memory-port, busy and done outputs.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      wait_phase_r  <= 1'b0;
      count_r       <= {ADDR_WIDTH{1'b0}};
      next_addr_r   <= {ADDR_WIDTH{1'b0}};
      mem_rden_r    <= 1'b0;
      mem_address_r <= {ADDR_WIDTH{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      mem_rden_r    <= 1'b0;
      mem_address_r <= {ADDR_WIDTH{1'b0}};
      done_r        <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r    <= ST_RD_CNT;
            mem_rden_r <= 1'b1;          // count word lives at address 0
            busy_r     <= 1'b1;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_RD_CNT: begin
          state_r      <= ST_WAIT_CNT;
          wait_phase_r <= 1'b0;
        end
        ST_WAIT_CNT: begin
          if (!wait_phase_r) begin
            wait_phase_r <= 1'b1;
          end else begin
            wait_phase_r <= 1'b0;
            count_r      <= clamp_count_s;
            if (clamp_count_s == {ADDR_WIDTH{1'b0}}) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              // First data read goes out in the first STREAM cycle.
              state_r       <= ST_STREAM;
              mem_rden_r    <= 1'b1;
              mem_address_r <= ADDR_WIDTH'(1'b1);
              next_addr_r   <= ADDR_WIDTH'(2'd2);
            end
          end
        end
        ST_STREAM: begin
          if (last_xfer_s) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else if (can_issue_s) begin
            mem_rden_r    <= 1'b1;
            mem_address_r <= next_addr_r;
            next_addr_r   <= next_addr_r + ADDR_WIDTH'(1'b1);
          end else begin
            state_r <= ST_STREAM;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  cell_pos_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .rst     (rst),
    .wr_en   (fly2_r),
    .wr_data ({fly2_addr_r, mem_q}),
    .rd_en   (pop_s),
    .rd_data (fifo_rd_data_s),
    .valid   (fifo_valid_s),
    .count   (fifo_count_s)
  );

endmodule
